sram_req_arbiter: RTL and testbench
===================================

# sram_req_arbiter

Two-master arbiter that shares one SRAM-like request/response port between the instruction-fetch requester (m0) and the load/store requester (m1), using the same req/addr_ok/data_ok handshake the fetch and memory stages drive. It sits between the pipeline stages and the single memory-side port (AXI bridge or unified cache). It tracks every outstanding transaction in an in-order ID FIFO so each `data_ok`/`rdata` beat is returned to the master that issued it.

## Interface
- `OUTSTANDING`, default 2: maximum accepted-but-unanswered transactions (ID FIFO depth); legal range 1–8.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `m0_req`/`m1_req`  in  1  master request
- `m0_wr`/`m1_wr`  in  1  1 = write
- `m0_size`/`m1_size`  in  2  0 = byte, 1 = half, 2 = word
- `m0_wstrb`/`m1_wstrb`  in  4  write byte strobes
- `m0_addr`/`m1_addr`  in  32  physical address
- `m0_wdata`/`m1_wdata`  in  32  write data
- `m0_addr_ok`/`m1_addr_ok`  out  1  request accepted this cycle
- `m0_data_ok`/`m1_data_ok`  out  1  response for this master this cycle
- `m0_rdata`/`m1_rdata`  out  32  read data; valid only with the matching data_ok
- `s_req`, `s_wr`, `s_size[1:0]`, `s_wstrb[3:0]`, `s_addr[31:0]`, `s_wdata[31:0]`  out: forwarded request fields from the granted master
- `s_addr_ok`, `s_data_ok`  in  1  slave handshakes
- `s_rdata`  in  32  slave read data

## Operation
- Grant selection: if `lock` is set, grant = `lock_id`. Otherwise priority is m1 > m0.
- `s_req = (m0_req | m1_req) & !fifo_full`. The `s_*` fields are muxed from the granted master. All `s_*` outputs are 0 when `s_req` = 0.
- `mX_addr_ok = s_addr_ok & s_req & (grant == X)`. The non-granted master never sees `addr_ok`.
- Lock:
  - Set when `s_req & !s_addr_ok`: `lock` <= 1, `lock_id` <= grant.
  - Cleared on the cycle `s_addr_ok` is sampled high.
  - While locked, a higher-priority request cannot steal the port.
  - If the locked master drops its req, the lock clears next cycle and arbitration resumes.
- ID FIFO, depth OUTSTANDING, 1-bit entries:
  - Push the grant ID on `s_req & s_addr_ok`.
  - Pop on `s_data_ok`.
  - Push and pop in the same cycle are both performed; count is unchanged.
- `mX_data_ok = s_data_ok & (fifo_head == X)`. `mX_rdata = s_rdata` when the head is X, else 0.
- `s_data_ok` with an empty FIFO is a protocol error. It is ignored: no data_ok to either master, no pop, and the FIFO does not underflow.
- `fifo_full` is evaluated on the registered count. A pop in the same cycle does not unblock a request; it becomes acceptable the next cycle.
- Pointers wrap modulo OUTSTANDING. Count width is clog2(OUTSTANDING+1).

## Timing
- Request path is combinational: `mX_req` -> `s_req`/`s_*` and `s_addr_ok` -> `mX_addr_ok` within the same cycle. Zero added latency.
- Response path is combinational: `s_data_ok`/`s_rdata` -> `mX_data_ok`/`mX_rdata` in the same cycle.
- Registered state updates at the clk edge: `lock`, `lock_id`, FIFO entries, read/write pointers, count, and the round-robin pointer.
- Reset:
  - FIFO empty; pointers and count 0.
  - `lock` = 0, `lock_id` = 0, round-robin pointer = m0.
  - All outputs 0 during and after reset until a req arrives.
- Reset asserted mid-transaction drops all outstanding IDs. Slave responses arriving after reset are treated as the empty-FIFO protocol error.

## Configuration
- `SRAM_ARB_RR_EN` defined:
  - Round-robin arbitration. An unlocked conflict grants the master not granted last.
  - The `rr_last` register is updated on every accepted handshake (`s_req & s_addr_ok`).
- Not defined: fixed priority m1 > m0; no `rr_last` register.
- Lock behaviour is identical in both builds.

## Test plan
- Single read: m0_req, addr 0x1c000000; s_addr_ok the same cycle, s_data_ok 2 cycles later with s_rdata 0x02c00000 -> m0_addr_ok 1 cycle, m0_data_ok 1 cycle with rdata 0x02c00000; m1 outputs stay 0.
- Conflict: m0 and m1 both req with s_addr_ok = 1 -> m1 granted first, m0 next cycle. With `SRAM_ARB_RR_EN` and two back-to-back conflicts -> m1, then m0.
- Lock: m0 req while s_addr_ok = 0 for 3 cycles, m1 req raised in cycle 2 -> s_addr stays m0_addr until m0_addr_ok; m1 is accepted afterwards.
- Ordering: m1 write 0x800 accepted, then m0 read 0x1c000004 accepted; two s_data_ok -> first goes to m1_data_ok, second to m0_data_ok.
- Full (OUTSTANDING = 2): two accepted with no data_ok -> s_req = 0 and both addr_ok = 0 on the third request. Pop plus req in the same cycle -> accepted the following cycle.
- Reset with 2 outstanding -> count 0; a subsequent s_data_ok produces no mX_data_ok.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-master SRAM-style request arbiter with an in-order ID FIFO for response routing.
// Optional build macro SRAM_ARB_RR_EN selects round-robin arbitration instead of fixed m1 > m0.
module sram_req_arbiter #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  typedef enum logic [1:0] {
    ARB_FREE,
    ARB_HOLD_M0,
    ARB_HOLD_M1
  } arb_state_t;

  arb_state_t state, state_next;

  logic             lock;
  logic             lock_id;
  logic             lock_hold;
  logic             grant;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  logic [OUTSTANDING-1:0] id_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

`ifdef SRAM_ARB_RR_EN
  logic rr_last;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Lock state register
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_FREE;
    else       state <= state_next;
  end

  // Any presented-but-unaccepted request holds the port for that master next cycle
  always_comb begin
    state_next = ARB_FREE;
    if (s_req && !s_addr_ok) state_next = grant ? ARB_HOLD_M1 : ARB_HOLD_M0;
  end

  always_comb begin
    lock    = (state != ARB_FREE);
    lock_id = (state == ARB_HOLD_M1);
  end

  // A lock only pins the grant while its owner still requests; otherwise arbitration resumes
  always_comb begin
    lock_hold = lock && (lock_id ? m1_req : m0_req);
    if (lock_hold) begin
      grant = lock_id;
    end else if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
      grant = ~rr_last;
`else
      grant = 1'b1;
`endif
    end else begin
      grant = m1_req;
    end
  end

  assign fifo_full  = (count == CNT_W'(OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign fifo_head  = id_mem[rd_ptr];

  assign s_req = (m0_req | m1_req) & ~fifo_full;
  assign push  = s_req & s_addr_ok;
  assign pop   = s_data_ok & ~fifo_empty;

  always_comb begin
    s_wr    = 1'b0;
    s_size  = '0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (s_req) begin
      if (grant) begin
        s_wr    = m1_wr;
        s_size  = m1_size;
        s_wstrb = m1_wstrb;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
      end else begin
        s_wr    = m0_wr;
        s_size  = m0_size;
        s_wstrb = m0_wstrb;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
      end
    end
  end

  assign m0_addr_ok = push & ~grant;
  assign m1_addr_ok = push &  grant;

  // Responses with nothing outstanding are dropped rather than routed
  always_comb begin
    m0_data_ok = pop & ~fifo_head;
    m1_data_ok = pop &  fifo_head;
    m0_rdata   = (!fifo_empty && !fifo_head) ? s_rdata : '0;
    m1_rdata   = (!fifo_empty &&  fifo_head) ? s_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= grant;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)     rr_last <= 1'b0;
    else if (push) rr_last <= grant;
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter (default build, OUTSTANDING = 2).
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_size = 2'd2; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
  endtask

  // Advance one cycle; inputs are driven 1 ns after the edge, checks happen 2 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    settle();
    tests++; if (s_req !== 1'b0) begin fails++; $display("FAIL reset_s_req got %0b want 0", s_req); end
    tests++; if ({m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok} !== 4'b0) begin
      fails++; $display("FAIL reset_handshakes got %b want 0000", {m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}); end
    tests++; if ({s_addr, s_wdata, m0_rdata, m1_rdata} !== 128'b0) begin
      fails++; $display("FAIL reset_data got %h %h %h %h want 0", s_addr, s_wdata, m0_rdata, m1_rdata); end
    step();
    reset = 0;
    step();
  endtask

  task automatic test_single_read();
    m0_req = 1; m0_addr = 32'h1c000000; s_addr_ok = 1;
    settle();
    tests++; if (s_req !== 1'b1 || s_addr !== 32'h1c000000) begin
      fails++; $display("FAIL single_req got s_req=%0b addr=%h want 1 1c000000", s_req, s_addr); end
    tests++; if ({m0_addr_ok, m1_addr_ok} !== 2'b10) begin
      fails++; $display("FAIL single_addr_ok got %b want 10", {m0_addr_ok, m1_addr_ok}); end
    step();
    m0_req = 0; s_addr_ok = 0;
    settle();
    tests++; if ({s_req, m0_addr_ok, m0_data_ok} !== 3'b000) begin
      fails++; $display("FAIL single_gap got %b want 000", {s_req, m0_addr_ok, m0_data_ok}); end
    step();
    s_data_ok = 1; s_rdata = 32'h02c00000;
    settle();
    tests++; if (m0_data_ok !== 1'b1 || m0_rdata !== 32'h02c00000) begin
      fails++; $display("FAIL single_data got ok=%0b rdata=%h want 1 02c00000", m0_data_ok, m0_rdata); end
    tests++; if (m1_data_ok !== 1'b0 || m1_rdata !== 32'h0) begin
      fails++; $display("FAIL single_m1_quiet got ok=%0b rdata=%h want 0 0", m1_data_ok, m1_rdata); end
    step();
    idle_inputs();
    settle();
    tests++; if (m0_data_ok !== 1'b0) begin fails++; $display("FAIL single_data_once got %0b want 0", m0_data_ok); end
    step();
  endtask

  task automatic test_conflict();
    m0_req = 1; m0_addr = 32'h00001000;
    m1_req = 1; m1_addr = 32'h00002000;
    s_addr_ok = 1;
    settle();
    tests++; if ({m1_addr_ok, m0_addr_ok} !== 2'b10 || s_addr !== 32'h00002000) begin
      fails++; $display("FAIL conflict_first got m1/m0=%b addr=%h want 10 00002000", {m1_addr_ok, m0_addr_ok}, s_addr); end
    step();
    m1_req = 0;
    settle();
    tests++; if ({m1_addr_ok, m0_addr_ok} !== 2'b01 || s_addr !== 32'h00001000) begin
      fails++; $display("FAIL conflict_second got m1/m0=%b addr=%h want 01 00001000", {m1_addr_ok, m0_addr_ok}, s_addr); end
    step();
    idle_inputs();
    s_data_ok = 1; s_rdata = 32'hAAAA0001;
    settle();
    tests++; if ({m1_data_ok, m0_data_ok} !== 2'b10 || m1_rdata !== 32'hAAAA0001) begin
      fails++; $display("FAIL conflict_resp1 got m1/m0=%b rdata=%h want 10 aaaa0001", {m1_data_ok, m0_data_ok}, m1_rdata); end
    step();
    s_rdata = 32'hAAAA0002;
    settle();
    tests++; if ({m1_data_ok, m0_data_ok} !== 2'b01 || m0_rdata !== 32'hAAAA0002) begin
      fails++; $display("FAIL conflict_resp2 got m1/m0=%b rdata=%h want 01 aaaa0002", {m1_data_ok, m0_data_ok}, m0_rdata); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_lock();
    m0_req = 1; m0_addr = 32'h1c000100;
    settle();
    tests++; if (s_req !== 1'b1 || s_addr !== 32'h1c000100 || m0_addr_ok !== 1'b0) begin
      fails++; $display("FAIL lock_c1 got req=%0b addr=%h ok=%0b want 1 1c000100 0", s_req, s_addr, m0_addr_ok); end
    step();
    m1_req = 1; m1_addr = 32'h00003000;
    settle();
    tests++; if (s_addr !== 32'h1c000100 || m1_addr_ok !== 1'b0) begin
      fails++; $display("FAIL lock_hold_c2 got addr=%h m1_ok=%0b want 1c000100 0", s_addr, m1_addr_ok); end
    step();
    settle();
    tests++; if (s_addr !== 32'h1c000100) begin
      fails++; $display("FAIL lock_hold_c3 got addr=%h want 1c000100", s_addr); end
    step();
    s_addr_ok = 1;
    settle();
    tests++; if ({m0_addr_ok, m1_addr_ok} !== 2'b10 || s_addr !== 32'h1c000100) begin
      fails++; $display("FAIL lock_accept got m0/m1=%b addr=%h want 10 1c000100", {m0_addr_ok, m1_addr_ok}, s_addr); end
    step();
    m0_req = 0;
    settle();
    tests++; if ({m0_addr_ok, m1_addr_ok} !== 2'b01 || s_addr !== 32'h00003000) begin
      fails++; $display("FAIL lock_after got m0/m1=%b addr=%h want 01 00003000", {m0_addr_ok, m1_addr_ok}, s_addr); end
    step();
    idle_inputs();
    s_data_ok = 1;
    settle();
    tests++; if ({m0_data_ok, m1_data_ok} !== 2'b10) begin
      fails++; $display("FAIL lock_resp1 got m0/m1=%b want 10", {m0_data_ok, m1_data_ok}); end
    step();
    settle();
    tests++; if ({m0_data_ok, m1_data_ok} !== 2'b01) begin
      fails++; $display("FAIL lock_resp2 got m0/m1=%b want 01", {m0_data_ok, m1_data_ok}); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_ordering();
    m1_req = 1; m1_wr = 1; m1_addr = 32'h00000800; m1_wstrb = 4'hf; m1_wdata = 32'hdeadbeef;
    s_addr_ok = 1;
    settle();
    tests++; if (m1_addr_ok !== 1'b1 || s_wr !== 1'b1 || s_wstrb !== 4'hf || s_wdata !== 32'hdeadbeef || s_addr !== 32'h800) begin
      fails++; $display("FAIL order_write got ok=%0b wr=%0b strb=%h wdata=%h addr=%h want 1 1 f deadbeef 00000800",
                        m1_addr_ok, s_wr, s_wstrb, s_wdata, s_addr); end
    step();
    m1_req = 0; m1_wr = 0;
    m0_req = 1; m0_addr = 32'h1c000004;
    settle();
    tests++; if (m0_addr_ok !== 1'b1 || s_wr !== 1'b0 || s_addr !== 32'h1c000004) begin
      fails++; $display("FAIL order_read got ok=%0b wr=%0b addr=%h want 1 0 1c000004", m0_addr_ok, s_wr, s_addr); end
    step();
    idle_inputs();
    s_data_ok = 1; s_rdata = 32'h11111111;
    settle();
    tests++; if ({m1_data_ok, m0_data_ok} !== 2'b10) begin
      fails++; $display("FAIL order_resp1 got m1/m0=%b want 10", {m1_data_ok, m0_data_ok}); end
    step();
    s_rdata = 32'h22222222;
    settle();
    tests++; if ({m1_data_ok, m0_data_ok} !== 2'b01 || m0_rdata !== 32'h22222222) begin
      fails++; $display("FAIL order_resp2 got m1/m0=%b rdata=%h want 01 22222222", {m1_data_ok, m0_data_ok}, m0_rdata); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_full();
    m0_req = 1; m0_addr = 32'h00004000; s_addr_ok = 1;
    step();
    step();
    m1_req = 1; m1_addr = 32'h00005000;
    settle();
    tests++; if ({s_req, m0_addr_ok, m1_addr_ok} !== 3'b000 || s_addr !== 32'h0) begin
      fails++; $display("FAIL full_block got req/ok0/ok1=%b addr=%h want 000 0", {s_req, m0_addr_ok, m1_addr_ok}, s_addr); end
    step();
    s_data_ok = 1;
    settle();
    tests++; if ({s_req, m1_addr_ok, m0_data_ok} !== 3'b001) begin
      fails++; $display("FAIL full_pop_same got req/ok1/dok0=%b want 001", {s_req, m1_addr_ok, m0_data_ok}); end
    step();
    s_data_ok = 0; m0_req = 0;
    settle();
    tests++; if ({s_req, m1_addr_ok} !== 2'b11) begin
      fails++; $display("FAIL full_next got req/ok1=%b want 11", {s_req, m1_addr_ok}); end
    step();
    idle_inputs();
    s_data_ok = 1;
    settle();
    tests++; if ({m0_data_ok, m1_data_ok} !== 2'b10) begin
      fails++; $display("FAIL full_drain1 got m0/m1=%b want 10", {m0_data_ok, m1_data_ok}); end
    step();
    settle();
    tests++; if ({m0_data_ok, m1_data_ok} !== 2'b01) begin
      fails++; $display("FAIL full_drain2 got m0/m1=%b want 01", {m0_data_ok, m1_data_ok}); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    m0_req = 1; m1_req = 1; s_addr_ok = 1;
    step();
    step();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    s_data_ok = 1; s_rdata = 32'h55555555;
    settle();
    tests++; if ({m0_data_ok, m1_data_ok} !== 2'b00 || {m0_rdata, m1_rdata} !== 64'b0) begin
      fails++; $display("FAIL reset_mid_drop got m0/m1=%b rdata=%h/%h want 00 0/0", {m0_data_ok, m1_data_ok}, m0_rdata, m1_rdata); end
    step();
    s_data_ok = 0;
    m0_req = 1; m0_addr = 32'h00006000; s_addr_ok = 1;
    settle();
    tests++; if (m0_addr_ok !== 1'b1) begin fails++; $display("FAIL reset_mid_acc1 got %0b want 1", m0_addr_ok); end
    step();
    settle();
    tests++; if (m0_addr_ok !== 1'b1) begin fails++; $display("FAIL reset_mid_acc2 got %0b want 1", m0_addr_ok); end
    step();
    idle_inputs();
    s_data_ok = 1;
    settle();
    tests++; if (m0_data_ok !== 1'b1) begin fails++; $display("FAIL reset_mid_resp got %0b want 1", m0_data_ok); end
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_single_read();
    test_conflict();
    test_lock();
    test_ordering();
    test_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
